// File: rtl/pattern_row_writer_if.sv
// Row-buffer write bus and memory-command handshake between the pattern
// writer (master) and the downstream row-buffer consumer (slave).
interface pattern_row_writer_if;
  logic [1:0]  buf_free;
  logic        command_ready;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_en_a;
  logic        wr_en_b;
  logic [1:0]  command_data;
  logic        command_valid;

  modport master (
    input  buf_free, command_ready,
    output wr_addr, wr_data, wr_en_a, wr_en_b, command_data, command_valid
  );

  modport slave (
    output buf_free, command_ready,
    input  wr_addr, wr_data, wr_en_a, wr_en_b, command_data, command_valid
  );
endinterface

// File: rtl/pattern_row_writer.sv
// RGB565 8-bar test-frame writer into ping-pong row buffers with row/frame commands.
// Optional feature macro: PATTERN_ANIMATION_EN (bars scroll left one pixel per frame).
module pattern_row_writer #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480
) (
  input  logic                            clk_cam,
  input  logic                            reset,
  input  logic                            enable,
  pattern_row_writer_if.master            bus,
  output logic [$clog2(FRAME_HEIGHT)-1:0] row_index,
  output logic                            busy
);
  localparam int WORDS = FRAME_WIDTH / 2;
  localparam int BAR_W = FRAME_WIDTH / 8;
  localparam int PW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam int RW    = $clog2(FRAME_HEIGHT);

  localparam logic [9:0]    LAST_WORD = 10'(WORDS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(FRAME_HEIGHT - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(BAR_W - 1);
  localparam logic [PW-1:0] POS_WRAP  = PW'(BAR_W - 2);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BUF  = 3'd1,
    FILL      = 3'd2,
    ROW_CMD   = 3'd3,
    FRAME_CMD = 3'd4
  } state_t;

  function automatic logic [15:0] bar_colour(input logic [2:0] bar);
    case (bar)
      3'd0:    return 16'hFFFF;
      3'd1:    return 16'hFFE0;
      3'd2:    return 16'h07FF;
      3'd3:    return 16'h07E0;
      3'd4:    return 16'hF81F;
      3'd5:    return 16'hF800;
      3'd6:    return 16'h001F;
      3'd7:    return 16'h0000;
      default: return 16'h0000;
    endcase
  endfunction

  state_t        state, state_n;
  logic          target, target_n;
  logic [2:0]    pix_bar, pix_bar_n;
  logic [PW-1:0] pix_pos, pix_pos_n;
  logic [RW-1:0] row_n;
  logic [9:0]    wr_addr_n;
  logic [31:0]   wr_data_n;
  logic          wr_en_a_n, wr_en_b_n;
  logic [1:0]    cmd_data_n;
  logic          cmd_valid_n;
  logic          emit;
  logic          frame_done;

  // Scroll offset kept as (bar, position-in-bar) so no divider is needed.
`ifdef PATTERN_ANIMATION_EN
  logic [2:0]    off_bar, off_bar_n;
  logic [PW-1:0] off_pos, off_pos_n;
`else
  logic [2:0]    off_bar;
  logic [PW-1:0] off_pos;
  assign off_bar = 3'd0;
  assign off_pos = '0;
`endif

  logic [2:0]    base_bar, adv_bar;
  logic [PW-1:0] base_pos, adv_pos;
  logic [31:0]   pair_data;

  // Pixel pair for the word about to be written and the position two columns on.
  always_comb begin
    if (state == FILL) begin
      base_bar = pix_bar;
      base_pos = pix_pos;
    end else begin
      base_bar = off_bar;
      base_pos = off_pos;
    end
    if (base_pos == POS_LAST) begin
      pair_data = {bar_colour(base_bar + 3'd1), bar_colour(base_bar)};
    end else begin
      pair_data = {bar_colour(base_bar), bar_colour(base_bar)};
    end
    if (base_pos >= POS_WRAP) begin
      adv_bar = base_bar + 3'd1;
      adv_pos = base_pos - POS_WRAP;
    end else begin
      adv_bar = base_bar;
      adv_pos = base_pos + PW'(2);
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_n     = state;
    target_n    = target;
    pix_bar_n   = pix_bar;
    pix_pos_n   = pix_pos;
    row_n       = row_index;
    wr_addr_n   = bus.wr_addr;
    wr_data_n   = bus.wr_data;
    wr_en_a_n   = 1'b0;
    wr_en_b_n   = 1'b0;
    cmd_data_n  = bus.command_data;
    cmd_valid_n = bus.command_valid;
    emit        = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        row_n    = '0;
        target_n = 1'b0;
        if (enable) begin
          state_n = WAIT_BUF;
        end else begin
          state_n = IDLE;
        end
      end
      WAIT_BUF: begin
        if (bus.buf_free[target]) begin
          state_n   = FILL;
          wr_addr_n = 10'd0;
          emit      = 1'b1;
        end else begin
          state_n = WAIT_BUF;
        end
      end
      FILL: begin
        if (bus.wr_addr == LAST_WORD) begin
          state_n     = ROW_CMD;
          cmd_valid_n = 1'b1;
          cmd_data_n  = target ? 2'd2 : 2'd1;
        end else begin
          wr_addr_n = bus.wr_addr + 10'd1;
          emit      = 1'b1;
        end
      end
      ROW_CMD: begin
        if (bus.command_ready) begin
          target_n = ~target;
          if (row_index == LAST_ROW) begin
            state_n     = FRAME_CMD;
            cmd_valid_n = 1'b1;
            cmd_data_n  = 2'd3;
          end else begin
            state_n     = WAIT_BUF;
            row_n       = row_index + RW'(1);
            cmd_valid_n = 1'b0;
            cmd_data_n  = 2'd0;
          end
        end else begin
          state_n = ROW_CMD;
        end
      end
      FRAME_CMD: begin
        if (bus.command_ready) begin
          frame_done  = 1'b1;
          row_n       = '0;
          cmd_valid_n = 1'b0;
          cmd_data_n  = 2'd0;
          state_n     = enable ? WAIT_BUF : IDLE;
        end else begin
          state_n = FRAME_CMD;
        end
      end
      default: begin
        state_n     = IDLE;
        cmd_valid_n = 1'b0;
        cmd_data_n  = 2'd0;
      end
    endcase
    if (emit) begin
      wr_en_a_n = ~target;
      wr_en_b_n = target;
      wr_data_n = pair_data;
      pix_bar_n = adv_bar;
      pix_pos_n = adv_pos;
    end else begin
      wr_en_a_n = 1'b0;
      wr_en_b_n = 1'b0;
    end
  end

  // State, pixel counters and all registered outputs.
  always_ff @(posedge clk_cam or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      target            <= 1'b0;
      pix_bar           <= 3'd0;
      pix_pos           <= '0;
      row_index         <= '0;
      bus.wr_addr       <= 10'd0;
      bus.wr_data       <= 32'd0;
      bus.wr_en_a       <= 1'b0;
      bus.wr_en_b       <= 1'b0;
      bus.command_data  <= 2'd0;
      bus.command_valid <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      target            <= target_n;
      pix_bar           <= pix_bar_n;
      pix_pos           <= pix_pos_n;
      row_index         <= row_n;
      bus.wr_addr       <= wr_addr_n;
      bus.wr_data       <= wr_data_n;
      bus.wr_en_a       <= wr_en_a_n;
      bus.wr_en_b       <= wr_en_b_n;
      bus.command_data  <= cmd_data_n;
      bus.command_valid <= cmd_valid_n;
      busy              <= (state_n != IDLE);
    end
  end

`ifdef PATTERN_ANIMATION_EN
  // Advance the scroll offset by one column on each accepted frame end.
  always_comb begin
    off_bar_n = off_bar;
    off_pos_n = off_pos;
    if (frame_done) begin
      if (off_pos == POS_LAST) begin
        off_bar_n = off_bar + 3'd1;
        off_pos_n = '0;
      end else begin
        off_pos_n = off_pos + PW'(1);
      end
    end else begin
      off_pos_n = off_pos;
    end
  end

  // Scroll offset register.
  always_ff @(posedge clk_cam or posedge reset) begin
    if (reset) begin
      off_bar <= 3'd0;
      off_pos <= '0;
    end else begin
      off_bar <= off_bar_n;
      off_pos <= off_pos_n;
    end
  end
`endif
endmodule

// File: tb/tb_pattern_row_writer.sv
// Scoreboard bench for pattern_row_writer: expected writes/commands are queued
// by the stimulus and popped by a monitor on each write strobe or command handshake.
module tb_pattern_row_writer;
  localparam int W     = 640;
  localparam int H     = 4;
  localparam int WORDS = W / 2;

  typedef struct packed {
    logic        is_cmd;
    logic        bsel;
    logic [9:0]  addr;
    logic [31:0] data;
    logic [1:0]  cmd;
  } exp_t;

  logic       clk_cam = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] row_index;
  logic       busy;
  pattern_row_writer_if bus();

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   model_off = 0;
  int   frame_off;

  always #5 clk_cam = ~clk_cam;

  pattern_row_writer #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
    .clk_cam   (clk_cam),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .row_index (row_index),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [15:0] colour(input int bar);
    case (bar)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] model_word(input int w, input int off);
    int c0;
    int c1;
    c0 = (2 * w + off) % W;
    c1 = (2 * w + 1 + off) % W;
    return {colour(c1 / (W / 8)), colour(c0 / (W / 8))};
  endfunction

  task automatic push_row(input logic bsel, input int off);
    exp_t e;
    for (int w = 0; w < WORDS; w++) begin
      e.is_cmd = 1'b0;
      e.bsel   = bsel;
      e.addr   = 10'(w);
      e.data   = model_word(w, off);
      e.cmd    = 2'd0;
      exp_q.push_back(e);
    end
    e = '0;
    e.is_cmd = 1'b1;
    e.cmd    = bsel ? 2'd2 : 2'd1;
    exp_q.push_back(e);
  endtask

  task automatic push_frame();
    exp_t e;
    for (int r = 0; r < H; r++) push_row(r[0], model_off);
    e = '0;
    e.is_cmd = 1'b1;
    e.cmd    = 2'd3;
    exp_q.push_back(e);
`ifdef PATTERN_ANIMATION_EN
    model_off = (model_off + 1) % W;
`endif
  endtask

  task automatic grab_word(input logic bsel, input int row, input int addr,
                           input logic [31:0] expv, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_cam);
      if ((bsel ? bus.wr_en_b : bus.wr_en_a) && bus.wr_addr == 10'(addr)
          && int'(row_index) == row) begin
        found = 1'b1;
        check(name, 64'(bus.wr_data), 64'(expv));
      end
    end
    if (!found) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_cmd_accept(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk_cam);
      if (bus.command_valid && bus.command_ready) found = 1'b1;
    end
    if (!found) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Monitor: pop expectations on every write strobe and command handshake.
  always @(negedge clk_cam) begin
    exp_t e;
    if (reset === 1'b0) begin
      check("excl", 64'({bus.wr_en_a & bus.wr_en_b,
                          (bus.wr_en_a | bus.wr_en_b) & bus.command_valid}), 64'd0);
      if (bus.wr_en_a || bus.wr_en_b) begin
        if (exp_q.size() == 0) check("unexpected_write", 64'(bus.wr_addr), 64'hFFFF);
        else begin
          e = exp_q.pop_front();
          check("write", 64'({1'b0, bus.wr_en_b, bus.wr_addr, bus.wr_data}),
                64'({e.is_cmd, e.bsel, e.addr, e.data}));
        end
      end
      if (bus.command_valid && bus.command_ready) begin
        if (exp_q.size() == 0) check("unexpected_cmd", 64'(bus.command_data), 64'hFF);
        else begin
          e = exp_q.pop_front();
          check("command", 64'({1'b1, bus.command_data}), 64'({e.is_cmd, e.cmd}));
        end
      end
    end
  end

  initial begin
    bit done;
    logic [1:0] held;
    reset = 1'b1;
    enable = 1'b0;
    bus.buf_free = 2'b01;
    bus.command_ready = 1'b1;
    repeat (3) @(negedge clk_cam);
    check("reset_outputs", 64'({bus.wr_addr, bus.wr_data, bus.wr_en_a, bus.wr_en_b,
                                bus.command_data, bus.command_valid, row_index, busy}), 64'd0);
    @(posedge clk_cam); #1 reset = 1'b0;
    @(negedge clk_cam);
    check("idle_busy", 64'(busy), 64'd0);

    // Frame 1: row 0 on A, then B stalled by buf_free[1]=0
    push_frame();
    @(posedge clk_cam); #1 enable = 1'b1;
    grab_word(1'b0, 0, 0,   32'hFFFF_FFFF, "f1_w0");
    grab_word(1'b0, 0, 40,  32'hFFE0_FFE0, "f1_w40");
    grab_word(1'b0, 0, 319, 32'h0000_0000, "f1_w319");
    wait_cmd_accept("row0_cmd");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_cam);
      check("stall_b", 64'({bus.wr_en_a, bus.wr_en_b, bus.command_valid, busy}), 64'b0001);
    end
    @(posedge clk_cam); #1;
    bus.buf_free = 2'b11;
    bus.command_ready = 1'b0;
    @(negedge clk_cam);
    check("b_not_yet", 64'(bus.wr_en_b), 64'd0);
    @(negedge clk_cam);
    check("b_first_strobe", 64'({bus.wr_en_b, bus.wr_addr}), 64'({1'b1, 10'd0}));

    // Command held while command_ready is low
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk_cam);
      if (bus.command_valid) done = 1'b1;
    end
    if (!done) check("cmd2_timeout", 64'd0, 64'd1);
    held = bus.command_data;
    check("cmd_hold", 64'({bus.command_valid, held, bus.wr_en_a | bus.wr_en_b}), 64'b1100);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_cam);
      check("cmd_hold", 64'({bus.command_valid, bus.command_data, bus.wr_en_a | bus.wr_en_b}),
            64'b1100);
    end
    @(posedge clk_cam); #1 bus.command_ready = 1'b1;
    wait_cmd_accept("row1_cmd");
    @(posedge clk_cam); #1 enable = 1'b0;

    // Frame completes despite enable low, then returns to IDLE
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk_cam);
      if (!busy) done = 1'b1;
    end
    if (!done) check("frame_end_timeout", 64'd0, 64'd1);
    check("frame1_idle", 64'({busy, row_index, bus.command_valid}), 64'd0);
    check("frame1_drain", 64'(exp_q.size()), 64'd0);

    // Frame 2 starts on buffer A with the new offset
    frame_off = model_off;
    push_frame();
    @(posedge clk_cam); #1 enable = 1'b1;
    grab_word(1'b0, 0, 0, model_word(0, frame_off), "f2_w0_on_a");
`ifdef PATTERN_ANIMATION_EN
    grab_word(1'b0, 0, 39, 32'hFFE0_FFFF, "f2_w39");
`else
    grab_word(1'b0, 0, 39, 32'hFFFF_FFFF, "f2_w39");
`endif
    grab_word(1'b0, 2, 100, model_word(100, frame_off), "f2_r2_w100");
    #1 reset = 1'b1;
    #1;
    check("reset_mid_row", 64'({bus.wr_addr, bus.wr_data, bus.wr_en_a, bus.wr_en_b,
                                bus.command_data, bus.command_valid, row_index, busy}), 64'd0);
    exp_q.delete();
    model_off = 0;
    push_row(1'b0, 0);
    @(posedge clk_cam); #1;
    @(posedge clk_cam); #1 reset = 1'b0;
    grab_word(1'b0, 0, 0, 32'hFFFF_FFFF, "restart_w0");
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk_cam);
      if (exp_q.size() == 0) done = 1'b1;
    end
    check("restart_drain", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
